ps2_rx_evt: RTL and testbench
=============================

Name: ps2_rx_evt

Overview:
- Parametrised next-generation PS/2 keyboard receiver.
- Filters the PS/2 clock, deframes 11-bit frames with start/stop checks and a timeout, and decodes E0/F0 prefixes into make/break events carrying an extended flag.
- Buffers events in a FIFO with a valid/ready handshake, so the game/display logic can drain keys at its own rate without losing them.
- Sits between the keyboard pins and the game controller and display.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised samples of ps2k_clk needed to accept a new level (1..15)
TIMEOUT_CYC, 50000, clk cycles with no accepted falling edge, mid-frame, before the frame is aborted
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ps2k_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2k_data  in  1  raw PS/2 data pin (asynchronous)
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head when evt_valid&evt_ready
evt_code  out  8  scan code of head event
evt_break  out  1  head is a break (key released)
evt_ext  out  1  head was E0-prefixed
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
key_held  out  1  1 while the most recent make code has not yet seen its matching break
overflow  out  1  sticky: an event was dropped because the FIFO was full
clr_ovf  in  1  single-cycle pulse clears overflow
frame_err  out  1  one-cycle pulse on framing error or timeout

Behaviour:
- Reset (rst low, async): all outputs 0 (evt_valid=0, fifo_count=0, key_held=0, overflow=0, frame_err=0); FSM to IDLE; prefix flags cleared; FIFO emptied. The filtered clock resets high.
- Input conditioning: ps2k_clk and ps2k_data each pass through 2 flops. The filtered clock changes only after FILTER_LEN equal consecutive samples. A fall event is a 1->0 transition of the filtered clock. Data is sampled on the cycle of the fall event.
- Frame FSM, advancing only on fall events:
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift bits LSB first; after 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: data=1 -> byte complete, back to IDLE; data=0 -> frame_err pulse, byte discarded, IDLE.
- Timeout: a counter runs while FSM != IDLE and resets on each fall event. Reaching TIMEOUT_CYC -> IDLE, frame_err pulse, partial byte discarded, prefix flags cleared.
- Prefix decode on byte complete:
  - 8'hE0 sets ext_f; 8'hF0 sets brk_f; neither pushes an event.
  - Any other byte pushes {code, brk_f, ext_f}, then clears both flags.
  - Any frame_err clears both flags.
- key_held:
  - Set on a make push; that push also records {code, ext}.
  - Cleared on a break push whose {code, ext} equals the recorded pair.
  - Other breaks leave it unchanged.
  - Updates even when the push is dropped for overflow.
- FIFO: first-word fall-through. A pushed event appears at the head (evt_valid=1) on the cycle after the STOP-bit fall event when the FIFO was empty.
  - Pop occurs when evt_valid&evt_ready.
  - Full + push with no pop: event dropped, overflow set.
  - Full + push + pop in the same cycle: both happen, no drop, count unchanged.
  - Empty + push: evt_ready is ignored that cycle.
- overflow is cleared by clr_ovf. If clr_ovf and a new drop coincide, overflow stays set.
- Outputs evt_code/evt_break/evt_ext are undefined when evt_valid=0; the bench must not check them then.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: odd parity is checked in STOP over data+parity. Mismatch -> frame_err pulse, byte discarded, prefixes cleared.
- Undefined: the parity bit is sampled and ignored; only start/stop/timeout produce frame_err.

Decomposition:
- Package ps2_pkg:
  - PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0.
  - Frame state enum {IDLE, DATA, PARITY, STOP}.
  - Event struct {code[7:0], brk, ext} (10 bits).
- One sub-module: ps2_evt_fifo, a generic synchronous FWFT FIFO (width, depth parameters; push/pop/full/empty/count) instantiated for events.

Test Plan:
- Send make 8'h1C, evt_ready=1 -> one event {1C,brk=0,ext=0}; evt_valid high the cycle after the stop-bit fall; key_held=1.
- Send F0,1C -> single event {1C,brk=1,ext=0}; key_held=0. Send E0,F0,75 after make E0,75 -> key_held 1 then 0, events ext=1.
- evt_ready=0, FIFO_DEPTH=8, send 9 makes -> fifo_count=8, overflow=1, 9th lost. Pulse clr_ovf -> overflow=0. Drain returns first 8 codes in order.
- Stop bit driven 0 on byte 8'h1D -> frame_err pulse, no event. Following valid 1D frame is accepted.
- Stop ps2k_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err, FSM IDLE. Also send F0, then timeout, then 1C -> event brk=0 (prefix cleared).
- With PS2_PARITY_CHECK_EN: send 1C with even parity -> frame_err, no event. Without the macro the same frame yields {1C,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receiver: prefix codes, frame states, event record.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module ps2_evt_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_rd;
  logic              do_wr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr = push & (~full | do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_rx_evt.sv
// PS/2 keyboard receiver: clock filter, frame deframer, E0/F0 prefix decode, event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_evt
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2k_clk,
  input  logic                          ps2k_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          key_held,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic ps2_clk_p0, ps2_clk_p1, ps2_dat_p0, ps2_dat_p1;
  logic filt_clk, flip, fall;
  logic [3:0] fcnt;
  ps2_state_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [TO_W-1:0] to_cnt;
  logic [7:0] shreg;
  logic err_now, byte_done, push_evt, pop, drop, full, empty, par_ok;
  logic ext_f, brk_f;
  logic [8:0] held_q;
  ps2_evt_t evt_in, head;

  // Stage p0/p1: two-flop synchronisers for the raw pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= ps2k_clk;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_dat_p0 <= ps2k_data;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  assign flip = (ps2_clk_p1 != filt_clk) && (fcnt == 4'(FILTER_LEN - 1));
  assign fall = flip & filt_clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk <= 1'b1;
      fcnt     <= '0;
    end else if (ps2_clk_p1 == filt_clk) begin
      fcnt <= '0;
    end else if (flip) begin
      filt_clk <= ps2_clk_p1;
      fcnt     <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (fall && state_q == PARITY) par_q <= ps2_dat_p1;
  end
  assign par_ok = ^{shreg, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    err_now   = 1'b0;
    byte_done = 1'b0;
    if (state_q != IDLE && !fall && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_now = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: if (!ps2_dat_p1) begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (ps2_dat_p1 && par_ok) byte_done = 1'b1;
          else                      err_now   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      to_cnt  <= (state_q == IDLE || fall) ? '0 : to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state_q == DATA) shreg <= {ps2_dat_p1, shreg[7:1]};
  end

  // Stage p2: event decode, FIFO push and status flags
  assign push_evt = byte_done && shreg != PS2_PREFIX_EXT && shreg != PS2_PREFIX_BRK;
  assign evt_in   = {shreg, brk_f, ext_f};
  assign pop      = evt_valid & evt_ready;
  assign drop     = push_evt & full & ~pop;

  ps2_evt_fifo #(.DATA_W($bits(ps2_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_evt),
    .din   (evt_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign evt_valid = ~empty;
  assign evt_code  = head.code;
  assign evt_break = head.brk;
  assign evt_ext   = head.ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      key_held  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_now;
      if (err_now) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (byte_done) begin
        if (shreg == PS2_PREFIX_EXT)      ext_f <= 1'b1;
        else if (shreg == PS2_PREFIX_BRK) brk_f <= 1'b1;
        else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
      // Tracks the key even when its event is dropped on overflow.
      if (push_evt) begin
        if (!brk_f)                            key_held <= 1'b1;
        else if ({shreg, ext_f} == held_q)     key_held <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_evt && !brk_f) held_q <= {shreg, ext_f};
  end

endmodule

// File: tb/tb_ps2_rx_evt.sv
// Directed bench for ps2_rx_evt: bit-banged PS/2 frames, hand-computed expected events.
`timescale 1ns/1ps
module tb_ps2_rx_evt;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int FIFO_DEPTH  = 8;

  logic clk = 1'b0, rst = 1'b0, ps2k_clk = 1'b1, ps2k_data = 1'b1;
  logic evt_ready = 1'b0, clr_ovf = 1'b0;
  logic evt_valid, evt_break, evt_ext, key_held, overflow, frame_err;
  logic [7:0] evt_code;
  logic [3:0] fifo_count;

  int checks = 0, failures = 0, err_cnt = 0, last_lat = 0;

  ps2_rx_evt #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .fifo_count(fifo_count),
    .key_held(key_held), .overflow(overflow), .clr_ovf(clr_ovf), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Low phase of a bit; when meas is set, records posedges until evt_valid rises.
  task automatic ps2_bit(input logic b, input bit meas);
    ps2k_data = b;
    wait_cyc(10);
    ps2k_clk = 1'b0;
    if (meas) begin
      last_lat = 0;
      for (int n = 1; n <= 20; n++) begin
        wait_cyc(1);
        if (evt_valid && last_lat == 0) last_lat = n;
      end
    end else begin
      wait_cyc(20);
    end
    ps2k_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop = 1'b1, input logic flip = 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(~^b ^ flip, 1'b0);
    ps2_bit(stop, 1'b1);
    ps2k_data = 1'b1;
    wait_cyc(10);
  endtask

  task automatic pop_evt(output logic [9:0] e, output bit got);
    got = 1'b0;
    e   = '0;
    for (int i = 0; i < 50; i++) begin
      if (evt_valid) begin got = 1'b1; break; end
      wait_cyc(1);
    end
    if (got) begin
      e = {evt_code, evt_break, evt_ext};
      evt_ready = 1'b1;
      wait_cyc(1);
      evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_cyc(3);
    checks++;
    if ({evt_valid, fifo_count, key_held, overflow, frame_err} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {evt_valid, fifo_count, key_held, overflow, frame_err});
    end
    rst = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_make();
    logic [9:0] e; bit got;
    send_frame(8'h1C);
    checks++;
    if (last_lat != 2 + FILTER_LEN) begin
      failures++; $display("FAIL make_latency got=%0d exp=%0d", last_lat, 2 + FILTER_LEN);
    end
    checks++;
    if (fifo_count !== 4'd1) begin failures++; $display("FAIL make_count got=%0d exp=1", fifo_count); end
    checks++;
    if (key_held !== 1'b1) begin failures++; $display("FAIL make_key_held got=%b exp=1", key_held); end
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1C, 1'b0, 1'b0}) begin
      failures++; $display("FAIL make_event got=%h valid=%0b exp=%h", e, got, {8'h1C, 2'b00});
    end
    checks++;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL make_drained got=%b exp=0", evt_valid); end
  endtask

  task automatic test_break();
    logic [9:0] e; bit got;
    send_frame(8'hF0);
    checks++;
    if (fifo_count !== 4'd0) begin failures++; $display("FAIL prefix_no_push got=%0d exp=0", fifo_count); end
    send_frame(8'h1C);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1C, 1'b1, 1'b0}) begin
      failures++; $display("FAIL break_event got=%h valid=%0b exp=%h", e, got, {8'h1C, 2'b10});
    end
    checks++;
    if (key_held !== 1'b0) begin failures++; $display("FAIL break_key_held got=%b exp=0", key_held); end
    checks++;
    if (err_cnt != 0) begin failures++; $display("FAIL no_spurious_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_ext();
    logic [9:0] e; bit got;
    send_frame(8'hE0); send_frame(8'h75);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h75, 1'b0, 1'b1}) begin
      failures++; $display("FAIL ext_make got=%h valid=%0b exp=%h", e, got, {8'h75, 2'b01});
    end
    checks++;
    if (key_held !== 1'b1) begin failures++; $display("FAIL ext_make_held got=%b exp=1", key_held); end
    send_frame(8'hF0); send_frame(8'h1D);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1D, 1'b1, 1'b0}) begin
      failures++; $display("FAIL other_break got=%h valid=%0b exp=%h", e, got, {8'h1D, 2'b10});
    end
    checks++;
    if (key_held !== 1'b1) begin failures++; $display("FAIL other_break_held got=%b exp=1", key_held); end
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h75, 1'b1, 1'b1}) begin
      failures++; $display("FAIL ext_break got=%h valid=%0b exp=%h", e, got, {8'h75, 2'b11});
    end
    checks++;
    if (key_held !== 1'b0) begin failures++; $display("FAIL ext_break_held got=%b exp=0", key_held); end
  endtask

  task automatic test_overflow();
    logic [9:0] e; bit got;
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i));
    checks++;
    if (fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    clr_ovf = 1'b1; wait_cyc(1); clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      pop_evt(e, got);
      checks++;
      if (!got || e !== {8'h10 + 8'(i), 2'b00}) begin
        failures++; $display("FAIL drain_%0d got=%h valid=%0b exp=%h", i, e, got, {8'h10 + 8'(i), 2'b00});
      end
    end
    checks++;
    if (evt_valid !== 1'b0 || fifo_count !== 4'd0) begin
      failures++; $display("FAIL drain_empty valid=%b count=%0d exp=0/0", evt_valid, fifo_count);
    end
  endtask

  task automatic test_stop_err();
    logic [9:0] e; bit got; int e0;
    e0 = err_cnt;
    send_frame(8'h1D, 1'b0);
    checks++;
    if (err_cnt != e0 + 1) begin failures++; $display("FAIL stop_err_pulse got=%0d exp=%0d", err_cnt - e0, 1); end
    checks++;
    if (fifo_count !== 4'd0) begin failures++; $display("FAIL stop_err_no_evt got=%0d exp=0", fifo_count); end
    send_frame(8'h1D);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1D, 2'b00}) begin
      failures++; $display("FAIL stop_err_recover got=%h valid=%0b exp=%h", e, got, {8'h1D, 2'b00});
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e; bit got; int e0;
    e0 = err_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
    wait_cyc(TIMEOUT_CYC + 50);
    checks++;
    if (err_cnt != e0 + 1) begin failures++; $display("FAIL timeout_pulse got=%0d exp=1", err_cnt - e0); end
    send_frame(8'h1C);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1C, 2'b00}) begin
      failures++; $display("FAIL timeout_recover got=%h valid=%0b exp=%h", e, got, {8'h1C, 2'b00});
    end
    send_frame(8'hF0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    wait_cyc(TIMEOUT_CYC + 50);
    send_frame(8'h1C);
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1C, 2'b00}) begin
      failures++; $display("FAIL timeout_prefix_clr got=%h valid=%0b exp=%h", e, got, {8'h1C, 2'b00});
    end
    checks++;
    if (err_cnt != e0 + 2) begin failures++; $display("FAIL timeout_pulse2 got=%0d exp=2", err_cnt - e0); end
  endtask

  task automatic test_parity();
    logic [9:0] e; bit got; int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checks++;
    if (err_cnt != e0 + 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
    checks++;
    if (fifo_count !== 4'd0) begin failures++; $display("FAIL parity_no_evt got=%0d exp=0", fifo_count); end
`else
    pop_evt(e, got);
    checks++;
    if (!got || e !== {8'h1C, 2'b00}) begin
      failures++; $display("FAIL parity_ignored got=%h valid=%0b exp=%h", e, got, {8'h1C, 2'b00});
    end
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL parity_no_err got=%0d exp=0", err_cnt - e0); end
`endif
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_overflow();
    test_stop_err();
    test_timeout();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
